// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into SEG ripple
// segments, one per stage, with valid/ready flow control and bubble collapsing.
module rca_pipe_addsub #(
   parameter int WIDTH = 32,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int W = WIDTH / SEG;

   logic [SEG:0]   en;
   logic [SEG-1:0] v;
   logic [SEG-1:0] c;
   logic           ovf_q;

   assign en[SEG] = out_ready;

   for (genvar k = 0; k < SEG; k++) begin : st
      // Operand bits still to be summed when the beat reaches this stage
      localparam int IW = WIDTH - k * W;

      logic [IW-1:0]      xa;
      logic [IW-1:0]      xb;
      logic               ci;
      logic               vin;
      logic [W:0]         t;
      logic [(k+1)*W-1:0] snext;
      logic [(k+1)*W-1:0] s;
      logic               vr;
      logic               cr;

      assign t = {1'b0, xa[W-1:0]} + {1'b0, xb[W-1:0]} + {{W{1'b0}}, ci};

      // The mode bit only matters here: later stages see pre-inverted B
      if (k == 0) begin : g_in
         assign xa    = a;
         assign xb    = sub ? ~b : b;
         assign ci    = sub | cin;
         assign vin   = in_valid;
         assign snext = t[W-1:0];
      end else begin : g_mid
         assign xa    = st[k-1].g_ops.ra;
         assign xb    = st[k-1].g_ops.rb;
         assign ci    = c[k-1];
         assign vin   = v[k-1];
         assign snext = {t[W-1:0], st[k-1].s};
      end

      // An empty stage always loads, so bubbles are squeezed out under stall
      assign en[k] = !vr || en[k+1];
      assign v[k]  = vr;
      assign c[k]  = cr;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vr <= 1'b0;
            cr <= 1'b0;
            s  <= '0;
         end else if (en[k]) begin
            vr <= vin;
            cr <= t[W];
            s  <= snext;
         end
      end

      if (k < SEG - 1) begin : g_ops
         logic [IW-W-1:0] ra;
         logic [IW-W-1:0] rb;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ra <= '0;
               rb <= '0;
            end else if (en[k]) begin
               ra <= xa[IW-1:W];
               rb <= xb[IW-1:W];
            end
         end
      end

      // Overflow: carry into the MSB (recovered from the sum bit) xor carry out
      if (k == SEG - 1) begin : g_last
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (en[k]) begin
               ovf_q <= (t[W-1] ^ xa[W-1] ^ xb[W-1]) ^ t[W];
            end
         end
      end
   end

   assign in_ready  = en[0];
   assign out_valid = v[SEG-1];
   assign sum       = st[SEG-1].s;
   assign cout      = c[SEG-1];
   assign ovf       = ovf_q;

endmodule
